// File: rtl/nic_pkg.sv
// nic_pkg
// Shared constants for the network interface controller: the default payload
// width used by buffer_nic, buffer_nic_fifo and the router ports, plus the
// flit field widths and flit type encoding the router ports agree on.
package nic_pkg;

    // Default payload width carried between the processor side and the router.
    localparam int NIC_DATA_SIZE = 64;

    // Flit layout shared with the router ports.
    localparam int FLIT_TYPE_W    = 2;
    localparam int FLIT_DEST_W    = 4;
    localparam int FLIT_PAYLOAD_W = NIC_DATA_SIZE - FLIT_TYPE_W - FLIT_DEST_W;

    typedef enum logic [FLIT_TYPE_W-1:0] {
        FLIT_HEAD   = 2'b00,
        FLIT_BODY   = 2'b01,
        FLIT_TAIL   = 2'b10,
        FLIT_SINGLE = 2'b11
    } flit_type_e;

    // Default FIFO geometry for the NIC buffer.
    localparam int NIC_FIFO_DEPTH = 4;

endpackage : nic_pkg

// File: rtl/nic_fifo_mem.sv
// nic_fifo_mem
// Register-array storage for buffer_nic_fifo: one synchronous write port and
// one asynchronous (combinational) read port. All entries clear on reset.
//
// Ports:
//   clk      - clock, writes occur on the rising edge
//   reset    - asynchronous active-low reset, zeroes every entry
//   i_we     - write enable
//   i_waddr  - write address
//   i_wdata  - write data
//   i_raddr  - read address
//   o_rdata  - entry at i_raddr, combinational
module nic_fifo_mem
    import nic_pkg::*;
#(
    parameter int DATA_SIZE = NIC_DATA_SIZE,
    parameter int DEPTH     = NIC_FIFO_DEPTH,
    parameter int ADDR_W    = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_we,
    input  logic [ADDR_W-1:0]    i_waddr,
    input  logic [DATA_SIZE-1:0] i_wdata,
    input  logic [ADDR_W-1:0]    i_raddr,
    output logic [DATA_SIZE-1:0] o_rdata
);

    logic [DATA_SIZE-1:0] r_mem [DEPTH];

    // Storage array; reset clears every slot so a freshly reset FIFO shows zero
    // on its read port.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule : nic_fifo_mem

// File: rtl/buffer_nic_fifo.sv
// buffer_nic_fifo
// DEPTH-entry show-ahead FIFO between the processor-side interface and the
// router port of the NIC. Provides full/empty/almost-full status, occupancy,
// a synchronous flush and sticky overflow/underflow flags.
//
// Ports:
//   clk         - clock, all state updates on the rising edge
//   reset       - asynchronous active-low reset
//   flush       - synchronous clear of pointers, count and error flags
//   Re          - pop request
//   We          - push request
//   data_in     - push payload
//   data_out    - head entry (valid while empty is low)
//   full        - count == DEPTH
//   empty       - count == 0
//   almost_full - count >= AF_LEVEL
//   count       - current occupancy, 0..DEPTH
//   ovf         - sticky: a push was rejected because the FIFO was full
//   udf         - sticky: a pop was rejected because the FIFO was empty
//
// DEPTH must be a power of two (pointers wrap by natural overflow).
module buffer_nic_fifo
    import nic_pkg::*;
#(
    parameter int DATA_SIZE = NIC_DATA_SIZE,
    parameter int DEPTH     = NIC_FIFO_DEPTH,
    parameter int AF_LEVEL  = DEPTH - 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         Re,
    input  logic                         We,
    input  logic [DATA_SIZE-1:0]         data_in,
    output logic [DATA_SIZE-1:0]         data_out,
    output logic                         full,
    output logic                         empty,
    output logic                         almost_full,
    output logic [$clog2(DEPTH):0]       count,
    output logic                         ovf,
    output logic                         udf
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam logic [ADDR_W:0] C_DEPTH = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] C_AF    = (ADDR_W+1)'(AF_LEVEL);

    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic              r_ovf;
    logic              r_udf;

    logic              w_re_do;
    logic              w_we_do;
    logic              w_mem_we;

    // A push while full is still accepted when a pop frees the head slot on
    // the same edge, which keeps one-in/one-out throughput at full occupancy.
    assign w_re_do  = Re & ~empty;
    assign w_we_do  = We & (~full | w_re_do);
    // Flush wins over a same-edge push, so the array must not be written.
    assign w_mem_we = w_we_do & ~flush;

    nic_fifo_mem #(
        .DATA_SIZE (DATA_SIZE),
        .DEPTH     (DEPTH),
        .ADDR_W    (ADDR_W)
    ) u_mem (
        .clk     (clk),
        .reset   (reset),
        .i_we    (w_mem_we),
        .i_waddr (r_wr_ptr),
        .i_wdata (data_in),
        .i_raddr (r_rd_ptr),
        .o_rdata (data_out)
    );

    // Pointer and occupancy tracking; simultaneous push and pop leave the
    // count untouched.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_we_do) begin
                r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
            end
            if (w_re_do) begin
                r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
            end
            case ({w_we_do, w_re_do})
                2'b10:   r_count <= r_count + (ADDR_W+1)'(1);
                2'b01:   r_count <= r_count - (ADDR_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky error flags, cleared only by flush or reset. Overflow is only
    // raised when no paired pop rescued the push.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ovf <= 1'b0;
            r_udf <= 1'b0;
        end else if (flush) begin
            r_ovf <= 1'b0;
            r_udf <= 1'b0;
        end else begin
            if (We & full & ~w_re_do) begin
                r_ovf <= 1'b1;
            end
            if (Re & empty) begin
                r_udf <= 1'b1;
            end
        end
    end

    assign count       = r_count;
    assign full        = (r_count == C_DEPTH);
    assign empty       = (r_count == '0);
    assign almost_full = (r_count >= C_AF);
    assign ovf         = r_ovf;
    assign udf         = r_udf;

endmodule : buffer_nic_fifo

// File: tb/tb_buffer_nic_fifo.sv
// tb_buffer_nic_fifo
// Directed scenarios followed by a randomized phase. A reference model updates
// on each rising edge and pushes accepted write data into a scoreboard queue;
// a monitor on the falling edge compares status against the model and checks
// the head entry whenever the FIFO presents data.
module tb_buffer_nic_fifo;

    localparam int DATA_SIZE = 64;
    localparam int DEPTH     = 4;
    localparam int AF_LEVEL  = DEPTH - 1;
    localparam int ADDR_W    = $clog2(DEPTH);

    logic                 clk = 1'b0;
    logic                 rstN;
    logic                 flush;
    logic                 re;
    logic                 we;
    logic [DATA_SIZE-1:0] dataIn;
    logic [DATA_SIZE-1:0] dataOut;
    logic                 full;
    logic                 empty;
    logic                 almostFull;
    logic [ADDR_W:0]      count;
    logic                 ovf;
    logic                 udf;

    int checks   = 0;
    int failures = 0;

    // Reference model state: expected data in arrival order plus occupancy
    // and sticky flags.
    logic [DATA_SIZE-1:0] sbQ [$];
    int                   mdlCount = 0;
    bit                   mdlOvf   = 1'b0;
    bit                   mdlUdf   = 1'b0;
    bit                   mdlRd;
    bit                   mdlWr;

    always #5 clk = ~clk;

    buffer_nic_fifo #(
        .DATA_SIZE (DATA_SIZE),
        .DEPTH     (DEPTH),
        .AF_LEVEL  (AF_LEVEL)
    ) dut (
        .clk         (clk),
        .reset       (rstN),
        .flush       (flush),
        .Re          (re),
        .We          (we),
        .data_in     (dataIn),
        .data_out    (dataOut),
        .full        (full),
        .empty       (empty),
        .almost_full (almostFull),
        .count       (count),
        .ovf         (ovf),
        .udf         (udf)
    );

    // Single comparison point: counts every check and reports any miss.
    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Drive one cycle of inputs just after an edge and return just after the
    // following edge, when that cycle's effect is visible.
    task automatic applyStimulus(input bit r, input bit w,
                                 input logic [DATA_SIZE-1:0] d, input bit f);
        re     = r;
        we     = w;
        dataIn = d;
        flush  = f;
        @(posedge clk);
        #1;
    endtask

    // Behavioural model: a FIFO of accepted writes with occupancy and flags,
    // updated from the rules for accepted operations.
    always @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            sbQ.delete();
            mdlCount = 0;
            mdlOvf   = 1'b0;
            mdlUdf   = 1'b0;
        end else if (flush) begin
            sbQ.delete();
            mdlCount = 0;
            mdlOvf   = 1'b0;
            mdlUdf   = 1'b0;
        end else begin
            mdlRd = re && (mdlCount > 0);
            mdlWr = we && ((mdlCount < DEPTH) || mdlRd);
            if (we && (mdlCount == DEPTH) && !mdlRd) mdlOvf = 1'b1;
            if (re && (mdlCount == 0))               mdlUdf = 1'b1;
            if (mdlWr) sbQ.push_back(dataIn);
            mdlCount = mdlCount + int'(mdlWr) - int'(mdlRd);
        end
    end

    // Monitor: compare status each cycle and the head entry whenever data is
    // presented; retire the head when a pop will be taken at the next edge.
    always @(negedge clk) begin
        if (rstN) begin
            checkOutput("count", 64'(count), 64'(mdlCount));
            checkOutput("empty", 64'(empty), 64'(mdlCount == 0));
            checkOutput("full", 64'(full), 64'(mdlCount == DEPTH));
            checkOutput("almostFull", 64'(almostFull), 64'(mdlCount >= AF_LEVEL));
            checkOutput("ovf", 64'(ovf), 64'(mdlOvf));
            checkOutput("udf", 64'(udf), 64'(mdlUdf));
            if (!empty) begin
                if (sbQ.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL headData: got 0x%0h, expected no data presented", dataOut);
                end else begin
                    checkOutput("headData", dataOut, sbQ[0]);
                    if (re && !flush) void'(sbQ.pop_front());
                end
            end
        end
    end

    initial begin
        rstN   = 1'b1;
        flush  = 1'b0;
        re     = 1'b0;
        we     = 1'b0;
        dataIn = '0;
        #1 rstN = 1'b0;
        #2;
        checkOutput("rstCount", 64'(count), 64'd0);
        checkOutput("rstEmpty", 64'(empty), 64'd1);
        checkOutput("rstFull", 64'(full), 64'd0);
        checkOutput("rstAf", 64'(almostFull), 64'd0);
        checkOutput("rstData", dataOut, 64'd0);
        checkOutput("rstOvf", 64'(ovf), 64'd0);
        checkOutput("rstUdf", 64'(udf), 64'd0);
        #9 rstN = 1'b1;

        $display("[TB] fill");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b1, 64'hA1 + 64'(i), 1'b0);
            checkOutput("fillCount", 64'(count), 64'(i + 1));
            checkOutput("fillAf", 64'(almostFull), 64'(i + 1 >= 3));
            checkOutput("fillFull", 64'(full), 64'(i + 1 == 4));
            checkOutput("fillHead", dataOut, 64'hA1);
        end

        $display("[TB] overflow");
        applyStimulus(1'b0, 1'b1, 64'hFF, 1'b0);
        checkOutput("ovfFlag", 64'(ovf), 64'd1);
        checkOutput("ovfCount", 64'(count), 64'd4);
        checkOutput("ovfHead", dataOut, 64'hA1);

        $display("[TB] drain");
        for (int i = 0; i < 4; i++) begin
            checkOutput("drainHead", dataOut, 64'hA1 + 64'(i));
            applyStimulus(1'b1, 1'b0, '0, 1'b0);
        end
        checkOutput("drainEmpty", 64'(empty), 64'd1);

        $display("[TB] underflow");
        applyStimulus(1'b1, 1'b1, 64'h55, 1'b0);
        checkOutput("udfFlag", 64'(udf), 64'd1);
        checkOutput("udfCount", 64'(count), 64'd1);
        checkOutput("udfHead", dataOut, 64'h55);

        $display("[TB] flush priority");
        applyStimulus(1'b0, 1'b1, 64'h66, 1'b0);
        applyStimulus(1'b0, 1'b1, 64'h67, 1'b0);
        checkOutput("preFlushCount", 64'(count), 64'd3);
        checkOutput("preFlushOvf", 64'(ovf), 64'd1);
        applyStimulus(1'b0, 1'b1, 64'hEE, 1'b1);
        checkOutput("flushCount", 64'(count), 64'd0);
        checkOutput("flushEmpty", 64'(empty), 64'd1);
        checkOutput("flushOvf", 64'(ovf), 64'd0);
        checkOutput("flushUdf", 64'(udf), 64'd0);

        $display("[TB] full streaming");
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 64'hC0 + 64'(i), 1'b0);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 1'b1, 64'hB0 + 64'(i), 1'b0);
            checkOutput("streamCount", 64'(count), 64'd4);
            checkOutput("streamFull", 64'(full), 64'd1);
            checkOutput("streamOvf", 64'(ovf), 64'd0);
        end
        for (int i = 0; i < 4; i++) begin
            checkOutput("streamTail", dataOut, 64'hB4 + 64'(i));
            applyStimulus(1'b1, 1'b0, '0, 1'b0);
        end

        $display("[TB] async reset");
        applyStimulus(1'b1, 1'b0, '0, 1'b0);
        applyStimulus(1'b0, 1'b1, 64'h1234, 1'b0);
        applyStimulus(1'b0, 1'b1, 64'h5678, 1'b0);
        applyStimulus(1'b0, 1'b0, '0, 1'b0);
        checkOutput("preRstCount", 64'(count), 64'd2);
        #2 rstN = 1'b0;
        #1;
        checkOutput("asyncCount", 64'(count), 64'd0);
        checkOutput("asyncEmpty", 64'(empty), 64'd1);
        checkOutput("asyncFull", 64'(full), 64'd0);
        checkOutput("asyncAf", 64'(almostFull), 64'd0);
        checkOutput("asyncData", dataOut, 64'd0);
        checkOutput("asyncUdf", 64'(udf), 64'd0);
        checkOutput("asyncOvf", 64'(ovf), 64'd0);
        #3 rstN = 1'b1;

        $display("[TB] random");
        for (int i = 0; i < 400; i++) begin
            int wPct;
            int rPct;
            wPct = (i < 200) ? 70 : 30;
            rPct = (i < 200) ? 30 : 70;
            applyStimulus($urandom_range(0, 99) < rPct,
                          $urandom_range(0, 99) < wPct,
                          {$urandom(), $urandom()},
                          $urandom_range(0, 31) == 0);
        end
        applyStimulus(1'b0, 1'b0, '0, 1'b0);
        applyStimulus(1'b0, 1'b0, '0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_buffer_nic_fifo

// File: doc/buffer_nic_fifo.md
# buffer_nic_fifo

Parametrised multi-entry successor to the single-entry NIC buffer. It sits between the processor-side interface and the router port of the network interface controller. It provides DEPTH-entry first-in-first-out buffering with show-ahead read data, full/empty/almost-full status, an occupancy count, a synchronous flush, and sticky overflow/underflow error flags.

## Interface
- DATA_SIZE, 64, payload width in bits
- DEPTH, 4, number of entries; power of two, ≥ 2
- AF_LEVEL, DEPTH-1, occupancy at which almost_full asserts; 1..DEPTH
- ADDR_W, $clog2(DEPTH), derived; not overridden

- clk  input  1  single clock; all state updates on rising edge
- reset  input  1  asynchronous, active-low reset
- flush  input  1  synchronous clear of contents and flags
- Re  input  1  read/pop request
- We  input  1  write/push request
- data_in  input  DATA_SIZE  write payload
- data_out  output  DATA_SIZE  head entry (show-ahead)
- full  output  1  count == DEPTH
- empty  output  1  count == 0
- almost_full  output  1  count ≥ AF_LEVEL
- count  output  ADDR_W+1  current occupancy 0..DEPTH
- ovf  output  1  sticky: write rejected because full
- udf  output  1  sticky: read rejected because empty

## Operation
- Storage is DEPTH × DATA_SIZE registers, with write pointer wr_ptr and read pointer rd_ptr, both ADDR_W bits wide. Pointers wrap naturally from DEPTH-1 to 0.
- Accepted operations:
  - Re_do = Re & !empty
  - We_do = We & (!full | Re_do)
- A write while full is accepted only when paired with an accepted read. This is new relative to the single-entry buffer.
- Push (We_do):
  - mem[wr_ptr] <= data_in
  - wr_ptr increments
- Pop (Re_do): rd_ptr increments.
- count update:
  - +1 on We_do only
  - -1 on Re_do only
  - unchanged when both or neither
- data_out = mem[rd_ptr] combinationally. It is valid whenever empty=0. When empty, it shows the stale slot value.
- No bypass. A write into an empty FIFO becomes visible on data_out the cycle after the edge. Re on an empty FIFO is rejected even if We is high in the same cycle.
- Error flags:
  - ovf sets on We & full & !Re_do.
  - udf sets on Re & empty.
  - Both stay set until flush or reset.
  - A rejected operation changes no other state.
- flush takes priority over Re and We on the same edge. It zeroes the pointers, count, ovf and udf. Memory contents are not cleared by flush.
- Reset (async assert, reset=0): all memory entries, pointers, count, ovf and udf go to 0.
  - Reset values: data_out=0, empty=1, full=0, almost_full=0, count=0, ovf=0, udf=0.
  - Reset asserted mid-operation discards all contents immediately, without waiting for a clock edge.

## Timing
- Write-to-read latency is 1 cycle. Data pushed at edge N appears on data_out and empty deasserts after edge N.
- full, empty, almost_full and count are decoded from registered count. They are valid after each edge and never lag by more than one edge.
- Sustained throughput is one push plus one pop per cycle at any occupancy, including full.
- Reset deassertion is synchronised externally. The block itself is not required to contain a reset synchroniser.

## Structure
- Shared package nic_pkg holds the DATA_SIZE default and the flit-width constants also used by buffer_nic and the router ports.
- One natural sub-module, nic_fifo_mem, contains the register array: one write port and an asynchronous read on rd_ptr, with async reset-to-zero.
- Pointer, count and flag logic live in the top level, buffer_nic_fifo.

## Test plan
- Reset then fill (DEPTH=4): push 0xA1..0xA4 on 4 cycles.
  - count steps 1,2,3,4.
  - almost_full rises at count 3; full rises at count 4.
  - data_out stays 0xA1 throughout.
  - Then 4 pops return 0xA1..0xA4 in order; empty=1 at the end.
- Overflow: when full, assert We alone with 0xFF. Required response: ovf=1, count stays 4, contents unchanged, and the next pop returns 0xA1.
- Underflow: when empty, assert Re and We together with 0x55. Required response:
  - udf=1.
  - The write is accepted: count=1, and data_out=0x55 next cycle.
- Simultaneous push/pop when full: hold Re=We=1 for 8 cycles with incrementing data. Required response:
  - count stays 4 and full stays 1.
  - Output order is preserved across pointer wrap.
  - ovf stays 0.
- Flush priority: with count=3 and ovf=1, assert flush together with We. Required response: count=0, empty=1, ovf=0, and the write is dropped.
- Async reset mid-stream: drop reset between clock edges while count=2. Required response: all outputs take their reset values immediately, before the next edge.
